mac_tx_framer: RTL and testbench

Ethernet MAC transmit framer for the UDP/IP stack, placed directly downstream of the 2:1 packet mux. It consumes the mux's 8-bit sop/eop/vld packet stream, which carries complete MAC frames with DA, SA, type and payload and no FCS. It buffers whole packets, then drives GMII with preamble/SFD, zero padding to the 60-byte minimum, CRC-32 FCS and a minimum inter-frame gap. The input has no backpressure, so packets that cannot be buffered whole are dropped and counted.

---
 rtl/mac_pkg.sv | 36 +++
 rtl/tx_pkt_fifo.sv | 68 ++++++
 rtl/mac_tx_framer.sv | 230 +++++++++++++++++++++++
 tb/tb_mac_tx_framer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, FSM states and CRC helper
// for the GMII transmit framer.
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          MIN_PAYLOAD   = 60;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_R    = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  // Reflected CRC-32, bit 0 of the byte enters first
  function automatic logic [31:0] crc32_d8(
    input logic [31:0] crc,
    input logic [7:0]  d
  );
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = {1'b0, c[31:1]} ^ CRC_POLY_R;
      else             c = {1'b0, c[31:1]};
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_pkt_fifo.sv
// Single-clock 9-bit packet buffer with a commit
// pointer; the reader only sees committed bytes.
module tx_pkt_fifo #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [8:0]    wr_dat_i,
  input  logic          rewind_i,
  input  logic          commit_i,
  input  logic          rd_en_i,
  output logic [8:0]    rd_dat_o,
  output logic [AW:0]   free_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

  logic [8:0]  mem_q [DEPTH];
  logic [8:0]  rd_dat_q;
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] cm_q, cm_d;
  logic [AW:0] rd_q;
  logic [AW:0] wr_base;

  // A rewind and the first byte of the next packet can share a cycle
  assign wr_base = rewind_i ? cm_q : wr_q;

  always_comb begin
    wr_d = wr_base;
    cm_d = cm_q;
    if (wr_en_i) begin
      wr_d = wr_base + ONE;
      if (commit_i) cm_d = wr_base + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q     <= '0;
      cm_q     <= '0;
      rd_q     <= '0;
      rd_dat_q <= '0;
    end else begin
      wr_q <= wr_d;
      cm_q <= cm_d;
      if (rd_en_i) begin
        rd_dat_q <= mem_q[rd_q[AW-1:0]];
        rd_q     <= rd_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_base[AW-1:0]] <= wr_dat_i;
  end

  assign rd_dat_o = rd_dat_q;
  assign free_o   = CAP - (cm_q - rd_q);
  assign full_o   = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o  = (cm_q == rd_q);

endmodule

// File: rtl/mac_tx_framer.sv
// Buffers whole packets and frames them onto GMII
// with preamble, zero pad, FCS and inter-frame gap.
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int FIFO_AW    = 11,
  parameter int MAX_FRAME  = 1514,
  parameter int IFG_CYCLES = 12
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_packet_sop,
  input  logic        in_packet_eop,
  input  logic        in_packet_vld,
  input  logic [7:0]  in_packet_dat,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        drop_pkt,
  output logic [15:0] tx_frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [FIFO_AW:0] ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] MAXF = (FIFO_AW+1)'(MAX_FRAME);
  localparam logic [7:0]  IFG_LAST  = 8'(IFG_CYCLES - 1);
  localparam logic [15:0] MIN_N     = 16'(MIN_PAYLOAD);

  logic [8:0]         rd_dat;
  logic [FIFO_AW:0]   fifo_free;
  logic               fifo_full, fifo_empty;
  logic               wr_en, rewind, commit, rd_req;

  logic               open_q, open_d;
  logic               drop_q, drop_d;
  logic [FIFO_AW:0]   pkt_cnt_q, pkt_cnt_d;
  logic [15:0]        frm_cnt_q, drp_cnt_q;

  tx_state_e          st_q, st_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        n_q, n_d;
  logic [31:0]        crc_q, crc_d;
  logic               eop_q, eop_d;
  logic [7:0]         txd_q, txd_d;
  logic               en_q, en_d;
  logic               pkt_dec, frm_inc;
  logic               start, take, tail, has_pkt;

  tx_pkt_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .wr_en_i  (wr_en),
    .wr_dat_i ({in_packet_eop, in_packet_dat}),
    .rewind_i (rewind),
    .commit_i (commit),
    .rd_en_i  (rd_req && !fifo_empty),
    .rd_dat_o (rd_dat),
    .free_o   (fifo_free),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    open_d = open_q;
    drop_d = 1'b0;
    wr_en  = 1'b0;
    rewind = 1'b0;
    commit = 1'b0;
    if (in_packet_vld) begin
      if (in_packet_sop) begin
        rewind = open_q;
        drop_d = open_q;
        if (fifo_free >= MAXF) begin
          wr_en  = 1'b1;
          commit = in_packet_eop;
          open_d = !in_packet_eop;
        end else begin
          drop_d = 1'b1;
          open_d = 1'b0;
        end
      end else if (open_q) begin
        if (fifo_full) begin
          rewind = 1'b1;
          drop_d = 1'b1;
          open_d = 1'b0;
        end else begin
          wr_en  = 1'b1;
          commit = in_packet_eop;
          open_d = !in_packet_eop;
        end
      end
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (commit && !pkt_dec)      pkt_cnt_d = pkt_cnt_q + ONE;
    else if (!commit && pkt_dec) pkt_cnt_d = pkt_cnt_q - ONE;
  end

  assign has_pkt = (pkt_cnt_q != '0);

  // Outputs are computed for the next cycle and registered
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    crc_d   = crc_q;
    eop_d   = eop_q;
    txd_d   = 8'h00;
    en_d    = 1'b0;
    rd_req  = 1'b0;
    pkt_dec = 1'b0;
    frm_inc = 1'b0;
    start   = 1'b0;
    take    = 1'b0;
    tail    = 1'b0;
    unique case (st_q)
      ST_IDLE: start = has_pkt;
      ST_PRE: begin
        en_d = 1'b1;
        if (cnt_q == 8'd6) begin
          st_d   = ST_SFD;
          txd_d  = SFD_BYTE;
          rd_req = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          txd_d = PREAMBLE_BYTE;
        end
      end
      ST_SFD:  take = 1'b1;
      ST_DATA: begin
        take = !eop_q;
        tail = eop_q;
      end
      ST_PAD:  tail = 1'b1;
      ST_FCS: begin
        if (cnt_q == 8'd3) begin
          st_d  = ST_IFG;
          cnt_d = 8'd0;
        end else begin
          en_d    = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          txd_d   = ~crc_q[7:0];
          crc_d   = {8'h00, crc_q[31:8]};
          frm_inc = (cnt_q == 8'd2);
        end
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          st_d  = ST_IDLE;
          start = has_pkt;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (start) begin
      st_d  = ST_PRE;
      cnt_d = 8'd0;
      n_d   = 16'd0;
      crc_d = CRC_INIT;
      txd_d = PREAMBLE_BYTE;
      en_d  = 1'b1;
    end
    // rd_dat holds the byte after the one on the wire
    if (take) begin
      st_d    = ST_DATA;
      en_d    = 1'b1;
      txd_d   = rd_dat[7:0];
      eop_d   = rd_dat[8];
      n_d     = n_q + 16'd1;
      crc_d   = crc32_d8(crc_q, rd_dat[7:0]);
      rd_req  = !rd_dat[8];
      pkt_dec = rd_dat[8];
    end
    if (tail) begin
      en_d = 1'b1;
      if (n_q < MIN_N) begin
        st_d  = ST_PAD;
        n_d   = n_q + 16'd1;
        crc_d = crc32_d8(crc_q, 8'h00);
      end else begin
        st_d  = ST_FCS;
        cnt_d = 8'd0;
        txd_d = ~crc_q[7:0];
        crc_d = {8'h00, crc_q[31:8]};
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      open_q    <= 1'b0;
      drop_q    <= 1'b0;
      pkt_cnt_q <= '0;
      frm_cnt_q <= '0;
      drp_cnt_q <= '0;
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      crc_q     <= CRC_INIT;
      eop_q     <= 1'b0;
      txd_q     <= '0;
      en_q      <= 1'b0;
    end else begin
      open_q    <= open_d;
      drop_q    <= drop_d;
      pkt_cnt_q <= pkt_cnt_d;
      if (frm_inc) frm_cnt_q <= frm_cnt_q + 16'd1;
      if (drop_d)  drp_cnt_q <= drp_cnt_q + 16'd1;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      crc_q     <= crc_d;
      eop_q     <= eop_d;
      txd_q     <= txd_d;
      en_q      <= en_d;
    end
  end

  assign gmii_txd     = txd_q;
  assign gmii_tx_en   = en_q;
  assign gmii_tx_er   = 1'b0;
  assign drop_pkt     = drop_q;
  assign tx_frame_cnt = frm_cnt_q;
  assign drop_cnt     = drp_cnt_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: expected GMII
// frames are queued at stimulus time and matched on output.
module tb_mac_tx_framer;
  import mac_pkg::*;

  localparam int IFG = 12;

  logic        sys_clk;
  logic        sys_rst;
  logic        in_packet_sop, in_packet_eop, in_packet_vld;
  logic [7:0]  in_packet_dat;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, gmii_tx_er, drop_pkt;
  logic [15:0] tx_frame_cnt, drop_cnt;

  mac_tx_framer #(
    .FIFO_AW(11), .MAX_FRAME(1514), .IFG_CYCLES(IFG)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .in_packet_sop (in_packet_sop),
    .in_packet_eop (in_packet_eop),
    .in_packet_vld (in_packet_vld),
    .in_packet_dat (in_packet_dat),
    .gmii_txd      (gmii_txd),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_tx_er    (gmii_tx_er),
    .drop_pkt      (drop_pkt),
    .tx_frame_cnt  (tx_frame_cnt),
    .drop_cnt      (drop_cnt)
  );

  initial sys_clk = 1'b0;
  always #4 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int sop_cyc = 0;
  int drop_cyc = -1;
  int n_drop_seen = 0;
  int er_seen = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  int gap = 0;
  bit gap_arm = 0;
  bit chk_gap = 0;
  bit in_frame = 0;
  bit discard = 0;

  logic [7:0] exp_b[$];
  int         exp_len[$];
  logic [7:0] rx[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tb_crc(input logic [31:0] c,
                                         input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ (r[0] ? 32'hEDB8_8320 : 32'h0);
    return r;
  endfunction

  task automatic frame_done();
    int len;
    logic [7:0] e;
    logic [31:0] c;
    bit bad;
    chk("frame_expected", 32'(exp_len.size() != 0), 32'd1);
    if (exp_len.size() == 0) begin
      rx.delete();
      return;
    end
    len = exp_len.pop_front();
    chk("frame_len", 32'(rx.size()), 32'(len));
    bad = 0;
    for (int i = 0; i < len; i++) begin
      e = exp_b.pop_front();
      if (!bad && i < rx.size()) begin
        chk("frame_byte", 32'(rx[i]), 32'(e));
        bad = (rx[i] !== e);
      end
    end
    if (rx.size() > 12) begin
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < rx.size(); i++) c = tb_crc(c, rx[i]);
      chk("crc_residue", c, CRC_RESIDUE);
    end
    rx.delete();
  endtask

  always @(negedge sys_clk) begin
    if (gmii_tx_er) er_seen++;
    if (drop_pkt) begin
      n_drop_seen++;
      drop_cyc = cyc;
    end
    if (gmii_tx_en) begin
      if (!in_frame && gap_arm) begin
        chk("ifg_gap", 32'(gap), 32'(IFG));
        gap_arm = 0;
      end
      in_frame = 1;
      rx.push_back(gmii_txd);
    end else if (in_frame) begin
      in_frame = 0;
      gap = 1;
      if (discard) begin
        rx.delete();
        discard = 0;
      end else begin
        frame_done();
      end
      gap_arm = chk_gap;
    end else begin
      gap++;
    end
  end

  // term=0 leaves the packet open; keep=1 queues the expected frame
  task automatic drive_pkt(input int len, input logic [7:0] b0,
                           input bit term, input bit keep);
    logic [7:0] d[$];
    logic [7:0] e;
    logic [31:0] c;
    int n;
    d.push_back(b0);
    for (int i = 1; i < len; i++) d.push_back(8'($urandom));
    for (int i = 0; i < len; i++) begin
      in_packet_vld = 1'b1;
      in_packet_sop = (i == 0);
      in_packet_eop = term && (i == len - 1);
      in_packet_dat = d[i];
      @(posedge sys_clk);
      #1;
      if (i == 0) sop_cyc = cyc;
    end
    in_packet_vld = 1'b0;
    in_packet_sop = 1'b0;
    in_packet_eop = 1'b0;
    in_packet_dat = 8'h00;
    if (keep) begin
      n = (len < 60) ? 60 : len;
      exp_len.push_back(8 + n + 4);
      exp_frames++;
      repeat (7) exp_b.push_back(8'h55);
      exp_b.push_back(8'hD5);
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
        e = (i < len) ? d[i] : 8'h00;
        exp_b.push_back(e);
        c = tb_crc(c, e);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) exp_b.push_back(c[8*i +: 8]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((exp_len.size() != 0 || in_frame) && t < 20000) begin
      @(negedge sys_clk);
      t++;
    end
    chk(tag, 32'(t < 20000), 32'd1);
    repeat (20) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int t;
    sys_rst = 1'b1;
    in_packet_vld = 1'b0;
    in_packet_sop = 1'b0;
    in_packet_eop = 1'b0;
    in_packet_dat = 8'h00;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    chk("rst_txd", 32'(gmii_txd), 32'd0);
    chk("rst_drop", 32'(drop_pkt), 32'd0);
    chk("rst_frames", 32'(tx_frame_cnt), 32'd0);
    chk("rst_drops", 32'(drop_cnt), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;

    drive_pkt(64, 8'h11, 1, 1);
    @(negedge sys_clk);
    chk("t1_cyc1_en", 32'(gmii_tx_en), 32'd0);
    @(negedge sys_clk);
    chk("t1_cyc2_en", 32'(gmii_tx_en), 32'd1);
    chk("t1_cyc2_txd", 32'(gmii_txd), 32'h55);
    wait_idle("t1_done");
    chk("t1_frames", 32'(tx_frame_cnt), 32'(exp_frames));

    drive_pkt(1, 8'hAB, 1, 1);
    wait_idle("t2_done");
    chk("t2_frames", 32'(tx_frame_cnt), 32'(exp_frames));

    chk_gap = 1;
    drive_pkt(100, 8'h21, 1, 1);
    drive_pkt(100, 8'h22, 1, 1);
    wait_idle("t3_done");
    chk_gap = 0;
    gap_arm = 0;
    chk("t3_frames", 32'(tx_frame_cnt), 32'(exp_frames));

    drive_pkt(20, 8'h31, 0, 0);
    drive_pkt(60, 8'h32, 1, 1);
    exp_drops++;
    chk("t4_drop_cyc", 32'(drop_cyc), 32'(sop_cyc));
    wait_idle("t4_done");
    chk("t4_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    chk("t4_frames", 32'(tx_frame_cnt), 32'(exp_frames));

    drive_pkt(535, 8'h41, 1, 1);
    drive_pkt(100, 8'h42, 1, 0);
    exp_drops++;
    chk("t5_drop_cyc", 32'(drop_cyc), 32'(sop_cyc));
    wait_idle("t5_done");
    chk("t5_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    chk("t5_frames", 32'(tx_frame_cnt), 32'(exp_frames));

    drive_pkt(534, 8'h51, 1, 1);
    drive_pkt(100, 8'h52, 1, 1);
    wait_idle("t6_done");
    chk("t6_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    chk("t6_frames", 32'(tx_frame_cnt), 32'(exp_frames));

    drive_pkt(200, 8'h61, 1, 1);
    t = 0;
    while (!gmii_tx_en && t < 200) begin
      @(posedge sys_clk);
      #1;
      t++;
    end
    chk("t7_started", 32'(gmii_tx_en), 32'd1);
    repeat (30) @(posedge sys_clk);
    #1;
    discard = 1;
    exp_len.delete();
    exp_b.delete();
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
    n_drop_seen = 0;
    @(negedge sys_clk);
    chk("t7_tx_en", 32'(gmii_tx_en), 32'd0);
    chk("t7_txd", 32'(gmii_txd), 32'd0);
    chk("t7_frames", 32'(tx_frame_cnt), 32'd0);
    chk("t7_drops", 32'(drop_cnt), 32'd0);
    repeat (4) @(posedge sys_clk);
    #1;
    drive_pkt(80, 8'h71, 1, 1);
    wait_idle("t7_done");
    chk("t7_new_frames", 32'(tx_frame_cnt), 32'(exp_frames));

    chk("end_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    chk("end_drop_pulses", 32'(n_drop_seen), 32'(exp_drops));
    chk("end_tx_er", 32'(er_seen), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
